// File: rtl/mem_resp_stage_pkg.sv
// Shared widths and state encoding for the MEM response stage.
package mem_resp_stage_pkg;
    localparam int unsigned MEM_WIDTH   = 32;
    localparam int unsigned MEM_RADDR   = 5;
    localparam int unsigned MEM_ECODE_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;
endpackage

// File: rtl/mem_resp_stage_discard.sv
// Counts data_sram responses still owed to instructions killed by a WB flush.
module resp_discard_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_wait,
    input  logic       addr_ok_fire,
    input  logic       data_ok,
    output logic [1:0] cnt
);
    logic [2:0] nxt;

    always_comb begin
        nxt = {1'b0, cnt};
        if (flush) begin
            // The flushed WAIT instruction and the request handshaking this cycle are both orphaned;
            // a response arriving now settles one of the outstanding requests.
            nxt = {1'b0, cnt} + 3'(in_wait) + 3'(addr_ok_fire)
                  - 3'(data_ok & ((cnt != 2'd0) | in_wait));
        end else if (data_ok && cnt != 2'd0) begin
            nxt = {1'b0, cnt} - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= nxt[1:0];
    end
endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage: holds one instruction, waits for its data_sram response, hands it to WB.
module mem_resp_stage
    import mem_resp_stage_pkg::*;
#(
    parameter int unsigned WIDTH   = MEM_WIDTH,
    parameter int unsigned RADDR   = MEM_RADDR,
    parameter int unsigned ECODE_W = MEM_ECODE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_to_mem_valid,
    output logic               mem_allowin,
    input  logic [WIDTH-1:0]   ex_pc,
    input  logic [WIDTH-1:0]   ex_result,
    input  logic [RADDR-1:0]   ex_dest,
    input  logic               ex_gpr_we,
    input  logic               ex_res_from_mem,
    input  logic               ex_mem_req_sent,
    input  logic [ECODE_W-1:0] ex_ecode,
    input  logic               ex_has_int,
    input  logic               ex_addr_ok_fire,
    input  logic               data_sram_data_ok,
    input  logic [WIDTH-1:0]   data_sram_rdata,
    input  logic               wb_allowin,
    input  logic               wb_flush,
    output logic               pipe_tonext_valid_MEM,
    output logic               mem_to_wb_valid,
    output logic [WIDTH-1:0]   pc_MEM,
    output logic [WIDTH-1:0]   alu_div_rdcntv_result_MEM,
    output logic [RADDR-1:0]   dest_MEM,
    output logic               gpr_we_MEM,
    output logic               res_from_mem_MEM,
    output logic [ECODE_W-1:0] ecode_MEM_m,
    output logic               has_int_MEM,
    output logic [WIDTH-1:0]   ld_res_from_MEM,
    output logic               mem_fwd_valid,
    output logic [RADDR-1:0]   mem_fwd_dest,
    output logic [WIDTH-1:0]   mem_fwd_data,
    output logic               mem_fwd_stall,
    output logic               mem_ex_block
);
    mem_state_e       state;
    logic             valid;
    logic [WIDTH-1:0] data_buf;
    logic [1:0]       discard_cnt;
    logic             data_live;
    logic             ready_go;
    logic             entry;

    resp_discard_ctr u_discard (
        .clk          (clk),
        .reset        (reset),
        .flush        (wb_flush),
        .in_wait      (valid && state == WAIT),
        .addr_ok_fire (ex_addr_ok_fire),
        .data_ok      (data_sram_data_ok),
        .cnt          (discard_cnt)
    );

    assign data_live             = data_sram_data_ok && discard_cnt == 2'd0 && state == WAIT;
    assign ready_go              = (state == DONE) || data_live;
    assign pipe_tonext_valid_MEM = valid && ready_go && wb_allowin && !wb_flush;
    assign mem_to_wb_valid       = pipe_tonext_valid_MEM;
    assign mem_allowin           = !reset && (!valid || pipe_tonext_valid_MEM);
    assign entry                 = ex_to_mem_valid && mem_allowin && !wb_flush;

    assign mem_fwd_valid = valid && gpr_we_MEM && dest_MEM != '0;
    assign mem_fwd_dest  = dest_MEM;
    assign mem_fwd_data  = !res_from_mem_MEM ? alu_div_rdcntv_result_MEM
                         : (data_live ? data_sram_rdata : data_buf);
    assign mem_fwd_stall = valid && res_from_mem_MEM && !ready_go;
    assign mem_ex_block  = valid && (ecode_MEM_m != '0 || has_int_MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            valid                     <= 1'b0;
            data_buf                  <= '0;
            ld_res_from_MEM           <= '0;
            pc_MEM                    <= '0;
            alu_div_rdcntv_result_MEM <= '0;
            dest_MEM                  <= '0;
            gpr_we_MEM                <= 1'b0;
            res_from_mem_MEM          <= 1'b0;
            ecode_MEM_m               <= '0;
            has_int_MEM               <= 1'b0;
        end else begin
            if (data_live) data_buf <= data_sram_rdata;
            if (pipe_tonext_valid_MEM)
                ld_res_from_MEM <= data_live ? data_sram_rdata : data_buf;

            if (wb_flush) begin
                valid <= 1'b0;
                state <= IDLE;
            end else if (entry) begin
                valid                     <= 1'b1;
                pc_MEM                    <= ex_pc;
                alu_div_rdcntv_result_MEM <= ex_result;
                dest_MEM                  <= ex_dest;
                gpr_we_MEM                <= ex_gpr_we;
                res_from_mem_MEM          <= ex_res_from_mem;
                ecode_MEM_m               <= ex_ecode;
                has_int_MEM               <= ex_has_int;
                // Exception-tagged instructions never wait for a response.
                state <= (ex_mem_req_sent && ex_ecode == '0 && !ex_has_int) ? WAIT : DONE;
            end else if (pipe_tonext_valid_MEM) begin
                valid <= 1'b0;
                state <= IDLE;
            end else if (data_live) begin
                state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage with a transfer scoreboard.
module tb_mem_resp_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_to_mem_valid, mem_allowin;
    logic [31:0] ex_pc, ex_result;
    logic [4:0]  ex_dest;
    logic        ex_gpr_we, ex_res_from_mem, ex_mem_req_sent;
    logic [5:0]  ex_ecode;
    logic        ex_has_int, ex_addr_ok_fire, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin, wb_flush;
    logic        pipe_tonext_valid_MEM, mem_to_wb_valid;
    logic [31:0] pc_MEM, alu_div_rdcntv_result_MEM;
    logic [4:0]  dest_MEM;
    logic        gpr_we_MEM, res_from_mem_MEM;
    logic [5:0]  ecode_MEM_m;
    logic        has_int_MEM;
    logic [31:0] ld_res_from_MEM;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_dest;
    logic [31:0] mem_fwd_data;
    logic        mem_fwd_stall, mem_ex_block;

    mem_resp_stage dut (
        .clk(clk), .reset(reset),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_dest(ex_dest),
        .ex_gpr_we(ex_gpr_we), .ex_res_from_mem(ex_res_from_mem),
        .ex_mem_req_sent(ex_mem_req_sent), .ex_ecode(ex_ecode), .ex_has_int(ex_has_int),
        .ex_addr_ok_fire(ex_addr_ok_fire), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin), .wb_flush(wb_flush),
        .pipe_tonext_valid_MEM(pipe_tonext_valid_MEM), .mem_to_wb_valid(mem_to_wb_valid),
        .pc_MEM(pc_MEM), .alu_div_rdcntv_result_MEM(alu_div_rdcntv_result_MEM),
        .dest_MEM(dest_MEM), .gpr_we_MEM(gpr_we_MEM), .res_from_mem_MEM(res_from_mem_MEM),
        .ecode_MEM_m(ecode_MEM_m), .has_int_MEM(has_int_MEM),
        .ld_res_from_MEM(ld_res_from_MEM), .mem_fwd_valid(mem_fwd_valid),
        .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data),
        .mem_fwd_stall(mem_fwd_stall), .mem_ex_block(mem_ex_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ld;
        bit          is_load;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          ld_pend = 1'b0;
    logic [31:0] ld_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_to_mem_valid   = 1'b0;
        ex_mem_req_sent   = 1'b0;
        ex_res_from_mem   = 1'b0;
        ex_gpr_we         = 1'b0;
        ex_ecode          = '0;
        ex_has_int        = 1'b0;
        ex_addr_ok_fire   = 1'b0;
        data_sram_data_ok = 1'b0;
        wb_flush          = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] pc, input bit fire);
        ex_to_mem_valid = 1'b1;
        ex_pc           = pc;
        ex_result       = pc + 32'h100;
        ex_dest         = 5'd5;
        ex_gpr_we       = 1'b1;
        ex_res_from_mem = 1'b1;
        ex_mem_req_sent = 1'b1;
        ex_addr_ok_fire = fire;
    endtask

    // Scoreboard: every transfer pops the oldest expected instruction.
    always @(negedge clk) begin
        if (!reset) begin
            if (ld_pend) begin
                chk("ld_res_after_transfer", ld_res_from_MEM, ld_exp);
                ld_pend = 1'b0;
            end
            if (pipe_tonext_valid_MEM) begin
                if (sb.size() == 0) begin
                    chk("unexpected_transfer", 32'(pipe_tonext_valid_MEM), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("transfer_pc", pc_MEM, e.pc);
                    chk("mem_to_wb_valid", 32'(mem_to_wb_valid), 32'd1);
                    if (e.is_load) begin
                        ld_pend = 1'b1;
                        ld_exp  = e.ld;
                    end
                end
            end
        end
    end

    initial begin
        idle_inputs();
        ex_pc = '0; ex_result = '0; ex_dest = '0; data_sram_rdata = '0;
        wb_allowin = 1'b1;
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_allowin", 32'(mem_allowin), 32'd0);
        chk("rst_pc", pc_MEM, 32'd0);
        chk("rst_ld_res", ld_res_from_MEM, 32'd0);
        chk("rst_pipe", 32'(pipe_tonext_valid_MEM), 32'd0);
        reset = 1'b0;
        cyc();

        // 1: load, data_ok three cycles after entry, WB ready
        drive_load(32'h1000, 1'b1);
        sb.push_back('{pc: 32'h1000, ld: 32'hDEADBEEF, is_load: 1'b1});
        @(negedge clk);
        chk("t1_allowin_idle", 32'(mem_allowin), 32'd1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("t1_stall", 32'(mem_fwd_stall), 32'd1);
        chk("t1_allowin_wait", 32'(mem_allowin), 32'd0);
        chk("t1_fwd_valid", 32'(mem_fwd_valid), 32'd1);
        cyc();
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_pipe_on_data_ok", 32'(pipe_tonext_valid_MEM), 32'd1);
        chk("t1_fwd_data", mem_fwd_data, 32'hDEADBEEF);
        chk("t1_no_stall", 32'(mem_fwd_stall), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("t1_allowin_after", 32'(mem_allowin), 32'd1);
        cyc();

        // 2: load data arrives while WB is blocked
        drive_load(32'h2000, 1'b1);
        sb.push_back('{pc: 32'h2000, ld: 32'h12345678, is_load: 1'b1});
        cyc();
        idle_inputs();
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h12345678;
        @(negedge clk);
        chk("t2_pipe_blocked", 32'(pipe_tonext_valid_MEM), 32'd0);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD0BAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_allowin_held", 32'(mem_allowin), 32'd0);
            chk("t2_ld_res_held", ld_res_from_MEM, 32'hDEADBEEF);
            chk("t2_fwd_buffered", mem_fwd_data, 32'h12345678);
            cyc();
        end
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("t2_pipe_release", 32'(pipe_tonext_valid_MEM), 32'd1);
        cyc();

        // 3: back-to-back ALU ops
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                ex_to_mem_valid = 1'b1;
                ex_pc           = 32'h3000 + 32'(i) * 4;
                ex_result       = 32'(i) * 32'h11 + 32'h5;
                ex_dest         = 5'd7;
                ex_gpr_we       = 1'b1;
                ex_res_from_mem = 1'b0;
                ex_mem_req_sent = 1'b0;
                sb.push_back('{pc: 32'h3000 + 32'(i) * 4, ld: '0, is_load: 1'b0});
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (i >= 1) begin
                chk("t3_pipe", 32'(pipe_tonext_valid_MEM), 32'd1);
                chk("t3_fwd_data", mem_fwd_data, 32'(i - 1) * 32'h11 + 32'h5);
                chk("t3_stall", 32'(mem_fwd_stall), 32'd0);
                chk("t3_allowin", 32'(mem_allowin), 32'd1);
            end
            cyc();
        end

        // 4: flush in WAIT while the next request handshakes
        drive_load(32'h4000, 1'b1);
        cyc();
        drive_load(32'h4004, 1'b1);
        wb_flush = 1'b1;
        @(negedge clk);
        chk("t4_pipe_flush", 32'(pipe_tonext_valid_MEM), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("t4_discard_cnt", 32'(dut.discard_cnt), 32'd2);
        drive_load(32'h4100, 1'b1);
        sb.push_back('{pc: 32'h4100, ld: 32'hCCCC0003, is_load: 1'b1});
        cyc();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA0001;
        @(negedge clk);
        chk("t4_drop1_pipe", 32'(pipe_tonext_valid_MEM), 32'd0);
        chk("t4_drop1_stall", 32'(mem_fwd_stall), 32'd1);
        cyc();
        data_sram_rdata = 32'hAAAA0002;
        @(negedge clk);
        chk("t4_discard_cnt1", 32'(dut.discard_cnt), 32'd1);
        chk("t4_drop2_pipe", 32'(pipe_tonext_valid_MEM), 32'd0);
        cyc();
        data_sram_rdata = 32'hCCCC0003;
        @(negedge clk);
        chk("t4_take3_pipe", 32'(pipe_tonext_valid_MEM), 32'd1);
        chk("t4_take3_fwd", mem_fwd_data, 32'hCCCC0003);
        cyc();
        idle_inputs();

        // 5: exception-tagged load never waits
        wb_allowin      = 1'b0;
        drive_load(32'h5000, 1'b0);
        ex_mem_req_sent = 1'b0;
        ex_ecode        = 6'h08;
        sb.push_back('{pc: 32'h5000, ld: '0, is_load: 1'b0});
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("t5_ex_block", 32'(mem_ex_block), 32'd1);
        chk("t5_ecode", 32'(ecode_MEM_m), 32'h8);
        chk("t5_no_stall", 32'(mem_fwd_stall), 32'd0);
        cyc();
        wb_allowin = 1'b1;
        @(negedge clk);
        chk("t5_pipe_no_data_ok", 32'(pipe_tonext_valid_MEM), 32'd1);
        cyc();

        // 6: async reset with a load waiting and a response owed
        drive_load(32'h6000, 1'b0);
        cyc();
        idle_inputs();
        wb_flush = 1'b1;
        cyc();
        idle_inputs();
        drive_load(32'h6100, 1'b1);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("t6_pre_cnt", 32'(dut.discard_cnt), 32'd1);
        chk("t6_pre_stall", 32'(mem_fwd_stall), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_pc", pc_MEM, 32'd0);
        chk("t6_async_stall", 32'(mem_fwd_stall), 32'd0);
        chk("t6_async_fwd_valid", 32'(mem_fwd_valid), 32'd0);
        chk("t6_async_cnt", 32'(dut.discard_cnt), 32'd0);
        chk("t6_async_ld_res", ld_res_from_MEM, 32'd0);
        chk("t6_async_allowin", 32'(mem_allowin), 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_idle_allowin", 32'(mem_allowin), 32'd1);
        chk("t6_idle_pipe", 32'(pipe_tonext_valid_MEM), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("ld_check_drained", 32'(ld_pend), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
